// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keypad front end: scan-code set 2
// constants, receiver state encoding and the code-to-Chip-8-key map.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Set-2 make codes for the 4x4 block 1234/QWER/ASDF/ZXCV
  localparam logic [7:0] SC_KEY_1 = 8'h16;
  localparam logic [7:0] SC_KEY_2 = 8'h1E;
  localparam logic [7:0] SC_KEY_3 = 8'h26;
  localparam logic [7:0] SC_KEY_C = 8'h25;
  localparam logic [7:0] SC_KEY_4 = 8'h15;
  localparam logic [7:0] SC_KEY_5 = 8'h1D;
  localparam logic [7:0] SC_KEY_6 = 8'h24;
  localparam logic [7:0] SC_KEY_D = 8'h2D;
  localparam logic [7:0] SC_KEY_7 = 8'h1C;
  localparam logic [7:0] SC_KEY_8 = 8'h1B;
  localparam logic [7:0] SC_KEY_9 = 8'h23;
  localparam logic [7:0] SC_KEY_E = 8'h2B;
  localparam logic [7:0] SC_KEY_A = 8'h1A;
  localparam logic [7:0] SC_KEY_0 = 8'h22;
  localparam logic [7:0] SC_KEY_B = 8'h21;
  localparam logic [7:0] SC_KEY_F = 8'h2A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_map_t;

  // Translate a non-extended scan code into a Chip-8 key index
  function automatic key_map_t map_scan_code(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = 4'h0;
    case (code)
      SC_KEY_0: m.idx = 4'h0;
      SC_KEY_1: m.idx = 4'h1;
      SC_KEY_2: m.idx = 4'h2;
      SC_KEY_3: m.idx = 4'h3;
      SC_KEY_4: m.idx = 4'h4;
      SC_KEY_5: m.idx = 4'h5;
      SC_KEY_6: m.idx = 4'h6;
      SC_KEY_7: m.idx = 4'h7;
      SC_KEY_8: m.idx = 4'h8;
      SC_KEY_9: m.idx = 4'h9;
      SC_KEY_A: m.idx = 4'hA;
      SC_KEY_B: m.idx = 4'hB;
      SC_KEY_C: m.idx = 4'hC;
      SC_KEY_D: m.idx = 4'hD;
      SC_KEY_E: m.idx = 4'hE;
      SC_KEY_F: m.idx = 4'hF;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the slow PS/2 clock/data, detects
// falling edges, assembles 11-bit frames and flags framing faults.
// o_byte_valid is a one-cycle strobe with no ready: o_byte is stable
// while it is high and the consumer must take it on that cycle.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int              TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TW-1:0]          r_tcnt;
  logic [7:0]             r_byte;
  logic                   r_byte_valid;
  logic                   r_frame_err;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_timeout;
  logic w_deliver;
  logic w_bad;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;
  // A falling edge in the same cycle wins over an expiring timeout
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_tcnt == TMAX);

  // Synchronizer chains, reset to the idle-high line level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  // Idle counter: cleared by each falling edge, saturates at the limit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt <= '0;
    end else if (w_fall) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TMAX) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Frame FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Frame FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_data_s) w_state_nxt = DATA;
        DATA:    if (r_bitcnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        STOP:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Frame FSM outputs: deliver a good byte or flag a fault on stop/timeout
  always_comb begin
    w_deliver = 1'b0;
    w_bad     = 1'b0;
    if (w_timeout) begin
      w_bad = 1'b1;
    end else if (w_fall && (r_state == STOP)) begin
      if (w_data_s && ((^r_shift) ^ r_parity)) w_deliver = 1'b1;
      else                                     w_bad     = 1'b1;
    end
  end

  // Shift register, bit counter, parity latch and registered strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_deliver;
      r_frame_err  <= w_bad;
      if (w_deliver) r_byte <= r_shift;
      if (w_fall) begin
        if (r_state == IDLE) begin
          r_bitcnt <= '0;
        end else if (r_state == DATA) begin
          r_shift  <= {w_data_s, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
        end else if (r_state == PARITY) begin
          r_parity <= w_data_s;
        end
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 set-2 keyboard to Chip-8 hex keypad decoder. Tracks E0/F0
// prefixes and keeps a held-key bitmap for the chip8 machine.
module ps2_keypad
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keys,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic        frame_err
);

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_frame_err;
  key_map_t    w_map;

  logic        r_ext;
  logic        r_brk;
  logic [15:0] r_keys;
  logic        r_event;
  logic [3:0]  r_code;
  logic        r_down;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  assign w_map = map_scan_code(w_byte);

  // Prefix tracking, key bitmap update and event strobe generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_keys  <= '0;
      r_event <= 1'b0;
      r_code  <= '0;
      r_down  <= 1'b0;
    end else begin
      r_event <= 1'b0;
      if (w_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BREAK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!r_ext && w_map.hit) begin
            r_keys[w_map.idx] <= ~r_brk;
            r_event           <= 1'b1;
            r_code            <= w_map.idx;
            r_down            <= ~r_brk;
          end
        end
      end
    end
  end

  assign keys      = r_keys;
  assign key_event = r_event;
  assign key_code  = r_code;
  assign key_down  = r_down;
  assign frame_err = w_frame_err;

endmodule

// File: doc/ps2_keypad.md
Name: ps2_keypad

Overview:
- Consumes the PS/2 keyboard stream (ps2_clk, ps2_data) produced by the user_io SPI bridge.
- Decodes scan-code set 2 make/break sequences and maintains the 16-key Chip-8 hex keypad state consumed by the chip8 machine.
- Sits between user_io and chip8 and runs in the 25 MHz video/system clock domain.
- Oversamples the slow PS/2 clock (10–16 kHz).

Parameters:
- TIMEOUT_CYCLES, 5000: idle clk cycles between PS/2 falling edges after which a partial frame is discarded (200 us at 25 MHz).
- SYNC_STAGES, 2: synchronizer depth for ps2_clk and ps2_data.

Ports:
- clk  input  1  system clock, 25 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  PS/2 clock from user_io, asynchronous to clk.
- ps2_data  input  1  PS/2 data from user_io, asynchronous to clk.
- keys  output  16  keypad state; bit n=1 while Chip-8 key n is held.
- key_event  output  1  one-cycle strobe on any mapped make or break.
- key_code  output  4  Chip-8 key index of the last event; valid with key_event.
- key_down  output  1  1=make, 0=break; valid with key_event.
- frame_err  output  1  one-cycle strobe on a bad start, parity, stop or timeout.

Behaviour:
- Reset: all outputs 0 (keys=16'h0000, key_event=0, key_code=0, key_down=0, frame_err=0). Receiver returns to IDLE and the prefix flags clear.
- Reset asserted mid-frame: the partial frame is dropped and held keys are released.
- Synchronizers: both inputs pass through SYNC_STAGES flops, reset to 1 (line idle high).
- A falling edge is synced ps2_clk going 1 then 0. Data is sampled on that cycle.
- Frame: 11 bits.
  - Start bit = 0.
  - 8 data bits, LSB first.
  - Odd parity bit: XOR of data bits and parity = 1.
  - Stop bit = 1.
- Receiver FSM:
  - IDLE: on an edge with data=0, go to DATA with bit count 0. An edge with data=1 is ignored as noise and raises no error.
  - DATA: shift 8 bits, then go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: on the edge, if stop=1 and parity is good, deliver the byte (1-cycle byte_valid internally). Otherwise pulse frame_err. Always return to IDLE.
- Timeout:
  - Counter resets on every falling edge.
  - In any state other than IDLE, reaching TIMEOUT_CYCLES pulses frame_err and returns to IDLE.
  - Counter saturates and does not wrap.
- Decoder, on byte_valid:
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Any other byte is a code. If ext=0 and the code is mapped to key n: keys[n] <= ~brk, key_event=1, key_code=n, key_down=~brk. Both flags clear after any code byte, mapped or not.
  - Extended codes (ext=1) are never mapped.
  - Unmapped codes produce no key_event.
- Mapping, set-2 code to Chip-8 key:
  - Row 1: 16→1, 1E→2, 26→3, 25→C.
  - Row 2: 15→4, 1D→5, 24→6, 2D→D.
  - Row 3: 1C→7, 1B→8, 23→9, 2B→E.
  - Row 4: 1A→A, 22→0, 21→B, 2A→F.
- Typematic repeat makes of a held key re-pulse key_event with key_down=1; keys is unchanged.
- A break for a key not held still pulses key_event; keys[n] stays 0.
- frame_err resets ext and brk so the next frame decodes cleanly.
- Latency: key_event and keys update 2 clk cycles after the synchronized falling edge that samples the stop bit (byte_valid register, then decoder register).

Decomposition:
- Package ps2_pkg holds:
  - The scan-code constants (SC_EXT=8'hE0, SC_BREAK=8'hF0, the 16 key codes).
  - The receiver state enum (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_rx: synchronizer, edge detector, frame FSM and timeout. Outputs byte, byte_valid and frame_err.
- ps2_keypad instantiates ps2_rx and holds the prefix flags, the mapping function and the keys register.

Test Plan:
- Send frame 8'h16 with parity 0 (three 1-bits, so parity=0) at a 12 kHz bit rate → keys=16'h0002, key_event one cycle, key_code=1, key_down=1, frame_err never asserted.
- After the previous case, send F0 then 16 → keys=16'h0000, one key_event with key_code=1 and key_down=0. No key_event on the F0 byte.
- Send 1C, then 2A, then E0 1C → keys=16'h8080 (keys 7 and F). The extended 1C causes no change and no key_event.
- Send 8'h22 with a wrong parity bit → frame_err one cycle, keys unchanged. The next good 8'h22 sets keys[0].
- Send start plus 4 data bits, then idle 6000 cycles → frame_err exactly once. A following full frame 8'h2D sets keys[13].
- Hold 1E, then assert reset_n=0 mid-frame of a second byte → all outputs 0 immediately. After release, a fresh 8'h26 frame gives keys=16'h0008.
